// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank: direction/mode encodings and step decode.
// Pure declarations; no state, no latency, no backpressure.
package counter_bank_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DN   = 2'd3
  } step_e;

  // Load always beats an enabled count step.
  function automatic step_e decode_step(input logic ld, input logic en, input logic dir);
    if (ld)
      return STEP_LOAD;
    else if (!en)
      return STEP_HOLD;
    else if (dir == DIR_UP)
      return STEP_UP;
    else
      return STEP_DN;
  endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Control/status bundle of the counter bank; master drives controls, slave returns counts.
// Wires only; no latency, no backpressure.
interface counter_bank_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);

  logic [NCH-1:0]       en;
  logic [NCH-1:0]       dir;
  logic [NCH-1:0]       sat;
  logic [NCH-1:0]       ld;
  logic [NCH*WIDTH-1:0] ld_val;
  logic [NCH*WIDTH-1:0] limit;
  logic [NCH-1:0]       clr_ovf;
  logic                 snap;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       tc;
  logic [NCH-1:0]       ovf;
  logic [NCH*WIDTH-1:0] snap_count;
  logic                 snap_valid;

  modport master (
    output en, dir, sat, ld, ld_val, limit, clr_ovf, snap,
    input  count, tc, ovf, snap_count, snap_valid
  );

  modport slave (
    input  en, dir, sat, ld, ld_val, limit, clr_ovf, snap,
    output count, tc, ovf, snap_count, snap_valid
  );

endinterface

// File: rtl/counter_bank_chan.sv
// counter_chan: one up/down counter with limit, wrap/saturate, tc pulse and sticky ovf.
// Outputs reflect cycle-t inputs at t+1; always accepts, no backpressure.
module counter_chan
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_clr_ovf,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  step_e            w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_bnd;
  logic             w_set_ovf;

  always_comb begin
    w_step    = decode_step(i_ld, i_en, i_dir);
    w_next    = r_count;
    w_bnd     = 1'b0;
    w_set_ovf = 1'b0;
    case (w_step)
      STEP_LOAD: w_next = i_ld_val;
      // >= so a loaded value above the limit still hits the boundary
      STEP_UP: begin
        if (r_count >= i_limit) begin
          w_bnd = 1'b1;
          if (i_sat == MODE_WRAP) begin
            w_next    = '0;
            w_set_ovf = 1'b1;
          end else begin
            w_next = i_limit;
          end
        end else begin
          w_next = r_count + ONE;
        end
      end
      STEP_DN: begin
        if (r_count == '0) begin
          w_bnd = 1'b1;
          if (i_sat == MODE_SAT) begin
            w_next = '0;
          end else begin
            w_next    = i_limit;
            w_set_ovf = 1'b1;
          end
        end else begin
          w_next = r_count - ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tc    <= w_bnd;
      // a wrap in the same cycle wins over the clear
      r_ovf   <= w_set_ovf | (r_ovf & ~i_clr_ovf);
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: NCH counter_chan instances plus a coherent all-channel snapshot register.
// Counts and snapshot update one cycle after the request; no backpressure.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  counter_bank_if.slave bus
);

  logic [NCH*WIDTH-1:0] w_count;
  logic [NCH-1:0]       w_tc;
  logic [NCH-1:0]       w_ovf;

  logic [NCH*WIDTH-1:0] r_snap_count;
  logic                 r_snap_valid;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    counter_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.en[g]),
      .i_dir     (bus.dir[g]),
      .i_sat     (bus.sat[g]),
      .i_ld      (bus.ld[g]),
      .i_ld_val  (bus.ld_val[g*WIDTH +: WIDTH]),
      .i_limit   (bus.limit[g*WIDTH +: WIDTH]),
      .i_clr_ovf (bus.clr_ovf[g]),
      .o_count   (w_count[g*WIDTH +: WIDTH]),
      .o_tc      (w_tc[g]),
      .o_ovf     (w_ovf[g])
    );
  end

  // Captures the registered (pre-update) counts, so every channel is from the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_count <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= bus.snap;
      if (bus.snap)
        r_snap_count <= w_count;
    end
  end

  assign bus.count      = w_count;
  assign bus.tc         = w_tc;
  assign bus.ovf        = w_ovf;
  assign bus.snap_count = r_snap_count;
  assign bus.snap_valid = r_snap_valid;

endmodule

// File: tb/tb_counter_bank.sv
// Directed vector bench for counter_bank (WIDTH=8, NCH=4) with two hand-written boundary sequences.
module tb_counter_bank;

  logic clk = 1'b0;
  logic rst;

  counter_bank_if #(.WIDTH(8), .NCH(4)) bus ();

  counter_bank #(.WIDTH(8), .NCH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  en, dir, sat, ld;
    logic [31:0] ld_val, limit;
    logic [3:0]  clr;
    logic        snap;
    logic [31:0] e_count;
    logic [3:0]  e_tc, e_ovf;
    logic [31:0] e_snap;
    logic        e_sv;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] p4(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic v(input logic r, input logic [3:0] en, input logic [3:0] dir, input logic [3:0] sat,
                   input logic [3:0] ld, input logic [31:0] ldv, input logic [31:0] lim,
                   input logic [3:0] clr, input logic snap, input logic [31:0] ec,
                   input logic [3:0] et, input logic [3:0] eo, input logic [31:0] es, input logic ev);
    vec_t t;
    t.rst = r; t.en = en; t.dir = dir; t.sat = sat; t.ld = ld; t.ld_val = ldv; t.limit = lim;
    t.clr = clr; t.snap = snap; t.e_count = ec; t.e_tc = et; t.e_ovf = eo; t.e_snap = es; t.e_sv = ev;
    vq.push_back(t);
  endtask

  task automatic put(input logic r, input logic [3:0] en, input logic [3:0] dir, input logic [3:0] sat,
                     input logic [3:0] ld, input logic [31:0] ldv, input logic [31:0] lim,
                     input logic [3:0] clr, input logic snap);
    rst = r; bus.en = en; bus.dir = dir; bus.sat = sat; bus.ld = ld; bus.ld_val = ldv;
    bus.limit = lim; bus.clr_ovf = clr; bus.snap = snap;
  endtask

  task automatic check(input string nm, input logic [31:0] ec, input logic [3:0] et,
                       input logic [3:0] eo, input logic [31:0] es, input logic ev);
    n_vec++;
    if (bus.count !== ec || bus.tc !== et || bus.ovf !== eo || bus.snap_count !== es || bus.snap_valid !== ev) begin
      n_err++;
      $display("FAIL %s: got count=%h tc=%b ovf=%b snap=%h sv=%b, want count=%h tc=%b ovf=%b snap=%h sv=%b",
               nm, bus.count, bus.tc, bus.ovf, bus.snap_count, bus.snap_valid, ec, et, eo, es, ev);
    end
  endtask

  initial begin
    logic [31:0] lim;
    logic [31:0] lim2;
    logic [31:0] lim9;
    logic [31:0] snap_a;
    logic [31:0] snap_b;
    int          steps;
    logic        found;
    logic [7:0]  sat_cnt [3];
    logic        sat_tc  [3];

    lim    = p4(255, 255, 255, 255);
    lim2   = p4(5, 255, 255, 255);
    lim9   = p4(255, 255, 9, 0);
    snap_a = p4(12, 22, 32, 42);
    snap_b = p4(13, 23, 33, 43);

    // reset with all enables high
    v(1, 4'hF, 4'hF, 4'h0, 4'h0, 0, lim, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0);
    v(1, 4'hF, 4'hF, 4'h0, 4'h0, 0, lim, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0);
    // ch0 up, wrap at limit 5
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim2, 4'h0, 0, p4(1,0,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim2, 4'h0, 0, p4(2,0,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim2, 4'h0, 0, p4(3,0,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim2, 4'h0, 0, p4(4,0,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim2, 4'h0, 0, p4(5,0,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim2, 4'h0, 0, p4(0,0,0,0), 4'h1, 4'h1, 0, 0);
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim2, 4'h0, 0, p4(1,0,0,0), 4'h0, 4'h1, 0, 0);
    // ch1 load 2 (ch0 ovf cleared), then saturating down
    v(0, 4'h0, 4'h0, 4'h0, 4'h2, p4(0,2,0,0), lim, 4'h1, 0, p4(1,2,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h2, 4'h0, 4'h2, 4'h0, 0, lim, 4'h0, 0, p4(1,1,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h2, 4'h0, 4'h2, 4'h0, 0, lim, 4'h0, 0, p4(1,0,0,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'h2, 4'h0, 4'h2, 4'h0, 0, lim, 4'h0, 0, p4(1,0,0,0), 4'h2, 4'h0, 0, 0);
    v(0, 4'h2, 4'h0, 4'h2, 4'h0, 0, lim, 4'h0, 0, p4(1,0,0,0), 4'h2, 4'h0, 0, 0);
    // ch2 ld beats en at limit; ch3 limit=0 wrap sets ovf despite clr_ovf
    v(0, 4'h0, 4'h0, 4'h0, 4'h4, p4(0,0,9,0), lim9, 4'h0, 0, p4(1,0,9,0), 4'h0, 4'h0, 0, 0);
    v(0, 4'hC, 4'hC, 4'h0, 4'h4, p4(0,0,3,0), lim9, 4'h8, 0, p4(1,0,3,0), 4'h8, 4'h8, 0, 0);
    v(0, 4'h8, 4'h0, 4'h0, 4'h4, p4(0,0,20,0), lim9, 4'h0, 0, p4(1,0,20,0), 4'h8, 4'h8, 0, 0);
    v(0, 4'h4, 4'h4, 4'h4, 4'h0, 0, lim9, 4'h8, 0, p4(1,0,9,0), 4'h4, 4'h0, 0, 0);
    v(0, 4'h4, 4'h4, 4'h0, 4'h0, 0, lim9, 4'h0, 0, p4(1,0,0,0), 4'h4, 4'h4, 0, 0);
    v(0, 4'h4, 4'h0, 4'h0, 4'h0, 0, lim9, 4'h0, 0, p4(1,0,9,0), 4'h4, 4'h4, 0, 0);
    // snapshot while counting, then back-to-back, then hold
    v(0, 4'h0, 4'h0, 4'h0, 4'hF, p4(10,20,30,40), lim, 4'h4, 0, p4(10,20,30,40), 4'h0, 4'h0, 0, 0);
    v(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, lim, 4'h0, 0, p4(11,21,31,41), 4'h0, 4'h0, 0, 0);
    v(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, lim, 4'h0, 0, snap_a, 4'h0, 4'h0, 0, 0);
    v(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, lim, 4'h0, 1, snap_b, 4'h0, 4'h0, snap_a, 1);
    v(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, lim, 4'h0, 1, snap_b, 4'h0, 4'h0, snap_b, 1);
    v(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, lim, 4'h0, 0, snap_b, 4'h0, 4'h0, snap_b, 0);
    // boundary + snap, then reset with both pending again
    v(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, p4(13,255,255,255), 4'h0, 1, p4(0,23,33,43), 4'h1, 4'h1, snap_b, 1);
    v(1, 4'h1, 4'h1, 4'h0, 4'h0, 0, p4(0,255,255,255), 4'h0, 1, 0, 4'h0, 4'h0, 0, 0);

    foreach (vq[i]) begin
      put(vq[i].rst, vq[i].en, vq[i].dir, vq[i].sat, vq[i].ld, vq[i].ld_val, vq[i].limit, vq[i].clr, vq[i].snap);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].e_count, vq[i].e_tc, vq[i].e_ovf, vq[i].e_snap, vq[i].e_sv);
    end

    // ch0 from 250 up to the 8-bit top: tc expected on the 6th step
    put(0, 4'h0, 4'h0, 4'h0, 4'h1, p4(250,0,0,0), lim, 4'h0, 0);
    @(posedge clk);
    #1;
    put(0, 4'h1, 4'h1, 4'h0, 4'h0, 0, lim, 4'h0, 0);
    steps = 0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #1;
      steps++;
      if (bus.tc[0] === 1'b1) found = 1'b1;
    end
    n_vec++;
    if (!found || steps != 6 || bus.count[7:0] !== 8'd0 || bus.ovf[0] !== 1'b1) begin
      n_err++;
      $display("FAIL wrap255: got found=%0d steps=%0d count0=%0d ovf0=%b, want found=1 steps=6 count0=0 ovf0=1",
               found, steps, bus.count[7:0], bus.ovf[0]);
    end

    // ch1 saturating up from 254: tc re-pulses while held at the limit
    put(0, 4'h0, 4'h0, 4'h0, 4'h2, p4(0,254,0,0), lim, 4'h0, 0);
    @(posedge clk);
    #1;
    sat_cnt[0] = 8'd255; sat_cnt[1] = 8'd255; sat_cnt[2] = 8'd255;
    sat_tc[0]  = 1'b0;   sat_tc[1]  = 1'b1;   sat_tc[2]  = 1'b1;
    put(0, 4'h2, 4'h2, 4'h2, 4'h0, 0, lim, 4'h0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.count[15:8] !== sat_cnt[k] || bus.tc[1] !== sat_tc[k] || bus.ovf[1] !== 1'b0) begin
        n_err++;
        $display("FAIL sat_up%0d: got count1=%0d tc1=%b ovf1=%b, want count1=%0d tc1=%b ovf1=0",
                 k, bus.count[15:8], bus.tc[1], bus.ovf[1], sat_cnt[k], sat_tc[k]);
      end
    end
    put(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, lim, 4'h0, 0);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
